rb_serial_tx: RTL and testbench
===============================

Name: rb_serial_tx

Overview:
Serial frame transmitter that feeds the RB2-side receiver on the sen/sd link. It reads 18 bytes (addresses 0..17) from the RB1 synchronous RAM and bit-transposes them into 8 frames of 18 data bits. Each frame goes out MSB-first as a 3-bit frame index followed by 18 data bits, 21 bits in total. It sits between RB1 and the serial link and is the transmit end of the frame protocol.

Parameters:
FRAMES, 8, number of frames sent; also the RB1 byte width.
IDX_W, 3, frame index width, log2(FRAMES).
DATA_W, 18, data bits per frame; also the number of RB1 words read.
MEM_AW, 5, RB1 address width.
MEM_DW, 8, RB1 data width.

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst  in  1  asynchronous, active-low reset.
RB1_RW  out  1  RB1 write-enable-bar; 1 = read.
RB1_A  out  MEM_AW  RB1 address.
RB1_D  out  MEM_DW  RB1 write data; unused.
RB1_Q  in  MEM_DW  RB1 read data; valid one cycle after address.
sen  out  1  frame enable; 0 = frame bit on sd.
sd  out  1  serial data, MSB-first.
tx_done  out  1  level; 1 once all frames are sent.

Behaviour:
- Reset (rst=0, asynchronous): all outputs forced to RB1_RW=1, RB1_A=0, RB1_D=0, sen=1, sd=0, tx_done=0. FSM goes to LOAD and the frame buffer clears.
- Reset asserted at any point, including mid-frame, aborts immediately: sen goes to 1 asynchronously. On release, the full sequence restarts from LOAD.
- RB1_RW and RB1_D are constant (1 and 0). The block never writes RB1.
- Transpose rule: frame n data bit k (17..0) = RB1[17-k] bit (7-n). Example: frame 0 takes bit 7 of bytes 0..17, with byte 0 as its MSB.
- The buffer is 8 x 18 flops. Loading byte a writes bit (7-n) into buffer[n][17-a] for all n in the same cycle.
- FSM states: LOAD, GAP, SEND, DONE.
- LOAD:
  - RB1_A steps 0,1,…,17, one per cycle, starting on the first edge after reset release.
  - The byte for address a is captured on the edge where RB1_A = a+1; address 17 is captured one edge after A=17.
  - LOAD lasts 19 cycles, then goes to GAP. RB1_A holds 17 afterwards.
- GAP: exactly 1 cycle with sen=1 and sd=0. Frame counter n starts at 0. Goes to SEND.
- SEND:
  - 21 consecutive cycles with sen=0.
  - sd carries, in order: n[2], n[1], n[0], then buffer[n][17] … buffer[n][0].
  - sen and sd are registered and change only just after a rising edge. They are stable at the next edge, where the receiver samples.
  - Bit counter runs 0..20. At 20: if n<7, n++ and go to GAP; if n=7, go to DONE.
- Consecutive frames are always separated by exactly one sen=1 cycle. Frame 0 starts 20 edges after reset release; frame n starts at 20+22n.
- DONE: sen=1, sd=0, tx_done=1. Held until reset; no further RB1 reads.
- Latency: last data bit at edge 20+22·7+20 = 194 after release. tx_done=1 from the next edge.
- Counter widths: bit counter 5 bits, byte counter 5 bits, frame counter IDX_W bits. The frame counter never wraps: exit to DONE happens at n=7.

Decomposition:
- Shared package rb_link_pkg holds:
  - Constants: FRAMES, IDX_W, DATA_W, FRAME_LEN=IDX_W+DATA_W (21), MEM_AW, MEM_DW.
  - FSM state enum for LOAD/GAP/SEND/DONE.
- The same package is reused by the receiver.
- One natural sub-module: rb_frame_shifter. It is a 21-bit parallel-load, MSB-first shift register that drives sd and handles bit counting and the sen timing. The top level keeps the load FSM and the transpose buffer.

Test Plan:
1. All RB1[0..17]=8'h80 -> frame 0 = 000 3FFFF; frames 1..7 carry their index with data 18'h00000. 8 frames total, tx_done=1 after edge 194.
2. RB1[0]=8'h01, others 0 -> frame 7 stream = 1,1,1,1 then 17 zeros (data 18'h20000); frames 0..6 data 0.
3. RB1[17]=8'hFF, others 0 -> every frame data = 18'h00001; index field 0..7 in order.
4. Frame spacing -> sen low for exactly 21 edges per frame, high for exactly 1 edge between frames. RB1_RW=1 and RB1_D=0 throughout. RB1_A sequence 0..17 over the first 18 edges.
5. Reset pulse at edge 60 (mid-frame 1) -> sen=1 immediately. After release, RB1_A restarts at 0 and frame 0 is re-sent at edge 20 with correct data.
6. Random RB1 contents with a reference-model transpose -> all 8 received frames match; no activity on sen after tx_done.

Source files
------------

// File: rtl/rb_link_pkg.sv
// Shared constants and FSM state type for the RB1 -> RB2 serial frame link.
// Used by both the transmit and the receive ends.
package rb_link_pkg;

    localparam int FRAMES    = 8;
    localparam int IDX_W     = 3;
    localparam int DATA_W    = 18;
    localparam int FRAME_LEN = IDX_W + DATA_W;
    localparam int MEM_AW    = 5;
    localparam int MEM_DW    = 8;
    localparam int CNT_W     = 5;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_GAP  = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/rb_frame_shifter.sv
// MSB-first parallel-load shift register for one link frame.
// Owns sen/sd timing and the bit counter; zero fill leaves sd low between frames.
module rb_frame_shifter
    import rb_link_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [FRAME_LEN-1:0] frame,
    output logic                 sen,
    output logic                 sd,
    output logic                 frame_end
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

    logic [FRAME_LEN-1:0] shreg_r;
    logic                 sen_r;
    logic [CNT_W-1:0]     bit_cnt_r;

    // Shift register, frame enable and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r   <= '0;
            sen_r     <= 1'b1;
            bit_cnt_r <= '0;
        end else if (load) begin
            shreg_r   <= frame;
            sen_r     <= 1'b0;
            bit_cnt_r <= '0;
        end else if (!sen_r) begin
            shreg_r <= {shreg_r[FRAME_LEN-2:0], 1'b0};
            if (bit_cnt_r == LAST_BIT) begin
                sen_r     <= 1'b1;
                bit_cnt_r <= '0;
            end else begin
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
        end
    end

    assign sd        = shreg_r[FRAME_LEN-1];
    assign sen       = sen_r;
    // True while the final bit of the frame is on the line.
    assign frame_end = !sen_r && (bit_cnt_r == LAST_BIT);

endmodule

// File: rtl/rb_serial_tx.sv
// Reads 18 bytes from RB1, bit-transposes them into 8 frames of 18 bits and
// sends each as {index, data} MSB-first on the sen/sd link.
module rb_serial_tx
    import rb_link_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic              RB1_RW,
    output logic [MEM_AW-1:0] RB1_A,
    output logic [MEM_DW-1:0] RB1_D,
    input  logic [MEM_DW-1:0] RB1_Q,
    output logic              sen,
    output logic              sd,
    output logic              tx_done
);

    localparam logic [MEM_AW-1:0] LAST_ADDR  = MEM_AW'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  LOAD_END   = CNT_W'(DATA_W);
    localparam logic [IDX_W-1:0]  LAST_FRAME = IDX_W'(FRAMES - 1);

    tx_state_e            state_r;
    tx_state_e            state_next_s;
    logic [CNT_W-1:0]     byte_cnt_r;
    logic [MEM_AW-1:0]    addr_r;
    logic [IDX_W-1:0]     frame_r;
    logic [DATA_W-1:0]    buf_r [FRAMES];
    logic                 tx_done_r;
    logic                 load_s;
    logic                 frame_end_s;
    logic [CNT_W-1:0]     bit_pos_s;
    logic [FRAME_LEN-1:0] frame_word_s;

    // RB1 is read-only from this side.
    assign RB1_RW  = 1'b1;
    assign RB1_D   = '0;
    assign RB1_A   = addr_r;
    assign tx_done = tx_done_r;

    // RAM data lags the address by one cycle, so byte (byte_cnt-1) lands in column 17-(byte_cnt-1).
    assign bit_pos_s = LOAD_END - byte_cnt_r;

    // State register and done flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_LOAD;
            tx_done_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            tx_done_r <= (state_next_s == ST_DONE);
        end
    end

    // Next-state and shifter load decode.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        case (state_r)
            ST_LOAD: begin
                if (byte_cnt_r == LOAD_END) begin
                    state_next_s = ST_GAP;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_GAP: begin
                load_s       = 1'b1;
                state_next_s = ST_SEND;
            end
            ST_SEND: begin
                if (frame_end_s) begin
                    if (frame_r == LAST_FRAME) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_GAP;
                    end
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            ST_DONE: state_next_s = ST_DONE;
            default: state_next_s = ST_LOAD;
        endcase
    end

    // RB1 address walk and transpose capture into the frame buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt_r <= '0;
            addr_r     <= '0;
            for (int n = 0; n < FRAMES; n++) begin
                buf_r[n] <= '0;
            end
        end else if (state_r == ST_LOAD) begin
            byte_cnt_r <= byte_cnt_r + CNT_W'(1);
            if (addr_r != LAST_ADDR) begin
                addr_r <= addr_r + MEM_AW'(1);
            end
            if (byte_cnt_r != CNT_W'(0)) begin
                for (int n = 0; n < FRAMES; n++) begin
                    buf_r[n][bit_pos_s] <= RB1_Q[MEM_DW-1-n];
                end
            end
        end
    end

    // Frame index advances after each frame except the last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_r <= '0;
        end else if ((state_r == ST_SEND) && frame_end_s && (frame_r != LAST_FRAME)) begin
            frame_r <= frame_r + IDX_W'(1);
        end
    end

    // Frame word presented to the shifter.
    always_comb begin
        frame_word_s = {frame_r, buf_r[frame_r]};
    end

    rb_frame_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst),
        .load      (load_s),
        .frame     (frame_word_s),
        .sen       (sen),
        .sd        (sd),
        .frame_end (frame_end_s)
    );

endmodule

// File: tb/tb_rb_serial_tx.sv
// Self-checking bench for rb_serial_tx: RB1 RAM model, link receiver and a
// frame-timing reference model derived from the transmit schedule.
module tb_rb_serial_tx;

    logic       clk;
    logic       rst;
    logic       RB1_RW;
    logic [4:0] RB1_A;
    logic [7:0] RB1_D;
    logic [7:0] RB1_Q;
    logic       sen;
    logic       sd;
    logic       tx_done;

    logic [7:0] mem [32];
    int n_cmp;
    int n_err;

    rb_serial_tx dut (
        .clk     (clk),
        .rst     (rst),
        .RB1_RW  (RB1_RW),
        .RB1_A   (RB1_A),
        .RB1_D   (RB1_D),
        .RB1_Q   (RB1_Q),
        .sen     (sen),
        .sd      (sd),
        .tx_done (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RB1 model.
    always @(posedge clk) RB1_Q <= mem[RB1_A];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Frame n data bit k is bit (7-n) of byte 17-k.
    function automatic logic [20:0] exp_word(input int n);
        logic [17:0] d;
        logic [2:0]  idx;
        for (int k = 0; k < 18; k++) d[k] = mem[17-k][7-n];
        idx = 3'(n);
        return {idx, d};
    endfunction

    // Frame n occupies the cycles after edges 20+22n .. 40+22n.
    function automatic int frame_at(input int e);
        for (int n = 0; n < 8; n++)
            if (e >= 20 + 22*n && e <= 40 + 22*n) return n;
        return -1;
    endfunction

    function automatic logic exp_sd(input int e);
        int n;
        logic [20:0] w;
        n = frame_at(e);
        if (n < 0) return 1'b0;
        w = exp_word(n);
        return w[20 - (e - 20 - 22*n)];
    endfunction

    task automatic run_sequence(input int cycles, input int abort_at);
        logic [20:0] rx_word;
        int rx_bits;
        int rx_frames;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_sen", 32'(sen), 32'd1);
        check_eq("rst_sd", 32'(sd), 32'd0);
        check_eq("rst_done", 32'(tx_done), 32'd0);
        check_eq("rst_addr", 32'(RB1_A), 32'd0);
        check_eq("rst_rw", 32'(RB1_RW), 32'd1);
        check_eq("rst_d", 32'(RB1_D), 32'd0);
        rst = 1'b1;
        rx_word = '0;
        rx_bits = 0;
        rx_frames = 0;
        for (int e = 0; e <= cycles; e++) begin
            if (e > 0) @(negedge clk);
            check_eq("sen", 32'(sen), (frame_at(e) >= 0) ? 32'd0 : 32'd1);
            check_eq("sd", 32'(sd), 32'(exp_sd(e)));
            check_eq("tx_done", 32'(tx_done), (e >= 195) ? 32'd1 : 32'd0);
            check_eq("addr", 32'(RB1_A), (e < 17) ? 32'(e) : 32'd17);
            check_eq("rw", 32'(RB1_RW), 32'd1);
            check_eq("wdata", 32'(RB1_D), 32'd0);
            if (!sen) begin
                rx_word = {rx_word[19:0], sd};
                rx_bits++;
            end else if (rx_bits != 0) begin
                check_eq("rx_len", 32'(rx_bits), 32'd21);
                check_eq("rx_frame", 32'(rx_word),
                         (rx_frames < 8) ? 32'(exp_word(rx_frames)) : 32'hFFFF_FFFF);
                rx_frames++;
                rx_bits = 0;
            end
            if (abort_at > 0 && e == abort_at) begin
                rst = 1'b0;
                #1;
                check_eq("abort_sen", 32'(sen), 32'd1);
                check_eq("abort_sd", 32'(sd), 32'd0);
                check_eq("abort_done", 32'(tx_done), 32'd0);
                check_eq("abort_addr", 32'(RB1_A), 32'd0);
                return;
            end
        end
        check_eq("rx_count", 32'(rx_frames), 32'd8);
    endtask

    task automatic fill_mem(input int mode);
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        for (int i = 0; i < 18; i++) begin
            case (mode)
                0:       mem[i] = 8'h80;
                1:       mem[i] = (i == 0) ? 8'h01 : 8'h00;
                2:       mem[i] = (i == 17) ? 8'hFF : 8'h00;
                default: mem[i] = 8'($urandom_range(255, 0));
            endcase
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        RB1_Q = 8'h00;

        fill_mem(0);
        run_sequence(230, 0);
        fill_mem(1);
        run_sequence(230, 0);
        fill_mem(2);
        run_sequence(230, 0);
        for (int r = 0; r < 3; r++) begin
            fill_mem(3);
            run_sequence(230, 0);
        end
        fill_mem(3);
        run_sequence(230, 60);
        run_sequence(230, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
